// File: rtl/channelizer_frame_buffer_if.sv
// Bundle of the frame buffer's sample-in / sample-out signals, named as on the
// block's ports, so a producer/consumer can carry them as one object.
interface channelizer_frame_buffer_if #(
  parameter int NUM_CHANNELS        = 32,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int DATA_WIDTH          = 25
);
  // Output handshake: a sample moves on every rising edge where Output_valid
  // and Output_ready are both 1; while Output_valid=1 and Output_ready=0 the
  // offered index/data/last hold. Input side has no back-pressure.
  logic                                 Input_valid;
  logic        [CHANNEL_INDEX_WIDTH-1:0] Input_index;
  logic signed [DATA_WIDTH-1:0]          Input_data [1:0];
  logic                                 Output_valid;
  logic                                 Output_ready;
  logic        [CHANNEL_INDEX_WIDTH-1:0] Output_index;
  logic signed [DATA_WIDTH-1:0]          Output_data [1:0];
  logic                                 Output_last;
  logic                                 Error_overflow;
  logic                                 Error_sequence;

  modport master (
    output Input_valid, Input_index, Input_data, Output_ready,
    input  Output_valid, Output_index, Output_data, Output_last,
           Error_overflow, Error_sequence
  );

  modport slave (
    input  Input_valid, Input_index, Input_data, Output_ready,
    output Output_valid, Output_index, Output_data, Output_last,
           Error_overflow, Error_sequence
  );
endinterface

// File: rtl/channelizer_frame_buffer.sv
// Ping-pong frame buffer: collects one in-order frame of channelizer samples
// per bank and replays completed frames through a valid/ready output.
module channelizer_frame_buffer #(
  parameter int NUM_CHANNELS        = 32,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int DATA_WIDTH          = 25
) (
  input  logic                                  Clk,
  input  logic                                  Rst,
  input  logic                                  Input_valid,
  input  logic        [CHANNEL_INDEX_WIDTH-1:0] Input_index,
  input  logic signed [DATA_WIDTH-1:0]          Input_data [1:0],
  output logic                                  Output_valid,
  input  logic                                  Output_ready,
  output logic        [CHANNEL_INDEX_WIDTH-1:0] Output_index,
  output logic signed [DATA_WIDTH-1:0]          Output_data [1:0],
  output logic                                  Output_last,
  output logic                                  Error_overflow,
  output logic                                  Error_sequence,
  output logic        [1:0]                     dbg_wr_state_o,
  output logic                                  dbg_rd_state_o
);
  // Output handshake: a sample transfers on a rising edge with
  // Output_valid=1 and Output_ready=1; while stalled all outputs hold.

  localparam int CIW = CHANNEL_INDEX_WIDTH;
  localparam int MW  = 2 * DATA_WIDTH;
  localparam logic [CIW-1:0] LAST_IDX = CIW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WRITE   = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Bank RAM, addressed {bank, index}; word is {Q, I}.
  logic [MW-1:0] mem_q [2*NUM_CHANNELS];

  wr_state_e   wr_state_q, wr_state_d;
  logic [CIW-1:0] expected_q, expected_d;
  logic        wr_bank_q, wr_bank_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_seq_q, err_seq_d;
  logic        mem_we;
  logic        full_set;

  rd_state_e   rd_state_q, rd_state_d;
  logic [CIW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_next;
  logic        rd_bank_q, rd_bank_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic signed [DATA_WIDTH-1:0] out_i_q, out_i_d;
  logic signed [DATA_WIDTH-1:0] out_q_q, out_q_d;
  logic        rd_load;
  logic        full_clr;
  logic [MW-1:0] rd_word;

  logic [1:0]  full_q, full_d;

  logic start_frame;
  logic bank_free;

  assign start_frame = Input_valid && (Input_index == '0);
  assign bank_free   = !full_q[wr_bank_q];

  // ---------------- write side ----------------
  always_comb begin
    wr_state_d = wr_state_q;
    expected_d = expected_q;
    wr_bank_d  = wr_bank_q;
    err_ovf_d  = 1'b0;
    err_seq_d  = 1'b0;
    mem_we     = 1'b0;
    full_set   = 1'b0;
    case (wr_state_q)
      WR_IDLE, WR_DISCARD: begin
        if (start_frame) begin
          if (bank_free) begin
            mem_we     = 1'b1;
            expected_d = CIW'(1);
            wr_state_d = WR_WRITE;
          end else begin
            err_ovf_d  = 1'b1;
            wr_state_d = WR_DISCARD;
          end
        end
      end
      WR_WRITE: begin
        if (Input_valid) begin
          if (Input_index == expected_q) begin
            mem_we = 1'b1;
            if (Input_index == LAST_IDX) begin
              full_set   = 1'b1;
              wr_bank_d  = ~wr_bank_q;
              expected_d = '0;
              wr_state_d = WR_IDLE;
            end else begin
              expected_d = expected_q + CIW'(1);
            end
          end else begin
            // A restart at index 0 reuses the bank of the aborted frame,
            // which was free when that frame began.
            err_seq_d = 1'b1;
            if (start_frame && bank_free) begin
              mem_we     = 1'b1;
              expected_d = CIW'(1);
            end else begin
              expected_d = '0;
              wr_state_d = WR_DISCARD;
            end
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_state_q <= WR_IDLE;
      expected_q <= '0;
      wr_bank_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      expected_q <= expected_d;
      wr_bank_q  <= wr_bank_d;
      err_ovf_q  <= err_ovf_d;
      err_seq_q  <= err_seq_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) begin
      mem_q[{wr_bank_q, Input_index}] <= {Input_data[1], Input_data[0]};
    end
  end

  // ---------------- read side ----------------
  always_comb begin
    rd_load     = 1'b0;
    rd_ptr_next = rd_ptr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_load     = 1'b1;
          rd_ptr_next = '0;
        end
      end
      RD_READ: begin
        if (out_valid_q && Output_ready && !out_last_q) begin
          rd_load     = 1'b1;
          rd_ptr_next = rd_ptr_q + CIW'(1);
        end
      end
      default: rd_load = 1'b0;
    endcase
  end

  assign rd_word = mem_q[{rd_bank_q, rd_ptr_next}];

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    full_clr    = 1'b0;
    if (rd_load) begin
      rd_ptr_d    = rd_ptr_next;
      out_valid_d = 1'b1;
      out_last_d  = (rd_ptr_next == LAST_IDX);
      out_i_d     = $signed(rd_word[DATA_WIDTH-1:0]);
      out_q_d     = $signed(rd_word[MW-1:DATA_WIDTH]);
      rd_state_d  = RD_READ;
    end else if (rd_state_q == RD_READ && out_valid_q && Output_ready && out_last_q) begin
      // Returning through IDLE guarantees a one-cycle valid gap between frames.
      full_clr    = 1'b1;
      rd_bank_d   = ~rd_bank_q;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      rd_state_d  = RD_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  // Set and clear always target different banks, so both can land together.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      full_d[b] = (full_q[b] || (full_set && (wr_bank_q == 1'(b))))
                  && !(full_clr && (rd_bank_q == 1'(b)));
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  assign Output_valid   = out_valid_q;
  assign Output_index   = rd_ptr_q;
  assign Output_data[0] = out_i_q;
  assign Output_data[1] = out_q_q;
  assign Output_last    = out_last_q;
  assign Error_overflow = err_ovf_q;
  assign Error_sequence = err_seq_q;
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_channelizer_frame_buffer.sv
// Self-checking bench for channelizer_frame_buffer: scoreboard of expected
// output samples plus per-scenario checks of errors, latency and reset.
module tb_channelizer_frame_buffer;
  localparam int NC  = 32;
  localparam int CIW = 5;
  localparam int DW  = 25;
  localparam int EW  = CIW + 2 * DW;
  localparam logic [CIW-1:0]       LAST_IDX = 5'd31;
  localparam logic signed [DW-1:0] MAX_V    = 25'sh0FFFFFF;
  localparam logic signed [DW-1:0] MIN_V    = 25'sh1000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  channelizer_frame_buffer_if #(
    .NUM_CHANNELS(NC), .CHANNEL_INDEX_WIDTH(CIW), .DATA_WIDTH(DW)
  ) bus ();

  logic [1:0] dbg_wr_state;
  logic       dbg_rd_state;

  channelizer_frame_buffer #(
    .NUM_CHANNELS(NC), .CHANNEL_INDEX_WIDTH(CIW), .DATA_WIDTH(DW)
  ) dut (
    .Clk           (clk),
    .Rst           (rst),
    .Input_valid   (bus.Input_valid),
    .Input_index   (bus.Input_index),
    .Input_data    (bus.Input_data),
    .Output_valid  (bus.Output_valid),
    .Output_ready  (bus.Output_ready),
    .Output_index  (bus.Output_index),
    .Output_data   (bus.Output_data),
    .Output_last   (bus.Output_last),
    .Error_overflow(bus.Error_overflow),
    .Error_sequence(bus.Error_sequence),
    .dbg_wr_state_o(dbg_wr_state),
    .dbg_rd_state_o(dbg_rd_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_w, got_w;
  int comps = 0, mism = 0;
  int xfers = 0, lasts = 0, ovf_cnt = 0, seq_cnt = 0, stall_checks = 0;
  int first_valid_cyc = -1;
  logic prev_stall = 1'b0, prev_last_xfer = 1'b0;
  logic [CIW-1:0] prev_idx;
  logic signed [DW-1:0] prev_i, prev_q;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (prev_stall) begin
        comps++; stall_checks++;
        if (bus.Output_valid !== 1'b1 || bus.Output_index !== prev_idx ||
            bus.Output_data[0] !== prev_i || bus.Output_data[1] !== prev_q) begin
          $display("FAIL stall_hold: got v=%b idx=%0d i=%0d q=%0d, need v=1 idx=%0d i=%0d q=%0d",
                   bus.Output_valid, bus.Output_index, bus.Output_data[0], bus.Output_data[1],
                   prev_idx, prev_i, prev_q);
          mism++;
        end
      end
      if (prev_last_xfer) begin
        comps++;
        if (bus.Output_valid !== 1'b0) begin
          $display("FAIL post_last_gap: Output_valid=%b, need 0", bus.Output_valid);
          mism++;
        end
      end
      if (bus.Output_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.Output_valid === 1'b1 && bus.Output_ready === 1'b1) begin
        xfers++;
        if (bus.Output_last === 1'b1) lasts++;
        got_w = {bus.Output_index, bus.Output_data[0], bus.Output_data[1]};
        comps++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: got %h, need no transfer", got_w);
          mism++;
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            $display("FAIL sample: got %h, need %h", got_w, exp_w);
            mism++;
          end
        end
        comps++;
        if (bus.Output_last !== (bus.Output_index == LAST_IDX)) begin
          $display("FAIL last_flag: idx=%0d last=%b", bus.Output_index, bus.Output_last);
          mism++;
        end
      end
      if (bus.Error_overflow === 1'b1 || bus.Error_sequence === 1'b1) begin
        if (bus.Error_overflow === 1'b1) ovf_cnt++;
        if (bus.Error_sequence === 1'b1) seq_cnt++;
        comps++;
        if (bus.Error_overflow === 1'b1 && bus.Error_sequence === 1'b1) begin
          $display("FAIL err_exclusive: ovf=1 seq=1, need at most one");
          mism++;
        end
      end
      prev_stall     = bus.Output_valid && !bus.Output_ready;
      prev_last_xfer = bus.Output_valid && bus.Output_ready && bus.Output_last;
      prev_idx       = bus.Output_index;
      prev_i         = bus.Output_data[0];
      prev_q         = bus.Output_data[1];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.Input_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_sample(input int idx, input logic signed [DW-1:0] di,
                              input logic signed [DW-1:0] dq, input bit push);
    bus.Input_valid   = 1'b1;
    bus.Input_index   = CIW'(idx);
    bus.Input_data[0] = di;
    bus.Input_data[1] = dq;
    if (push) exp_q.push_back({CIW'(idx), di, dq});
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int base, input bit push);
    for (int k = 0; k < NC; k++) drive_sample(k, DW'(base + k), DW'(-(base + k)), push);
    bus.Input_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int n = 0;
    while ((exp_q.size() != 0 || bus.Output_valid === 1'b1) && n < budget) begin
      if (toggle) bus.Output_ready = ~bus.Output_ready;
      @(posedge clk); #1;
      n++;
    end
    comps++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d samples still expected, need 0", exp_q.size());
      mism++;
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    comps++;
    if (bus.Output_valid !== 1'b0 || bus.Output_last !== 1'b0 || bus.Output_index !== '0) begin
      $display("FAIL %s_ctrl: v=%b last=%b idx=%0d, need 0/0/0", tag,
               bus.Output_valid, bus.Output_last, bus.Output_index);
      mism++;
    end
    comps++;
    if (bus.Output_data[0] !== '0 || bus.Output_data[1] !== '0) begin
      $display("FAIL %s_data: i=%0d q=%0d, need 0/0", tag, bus.Output_data[0], bus.Output_data[1]);
      mism++;
    end
    comps++;
    if (bus.Error_overflow !== 1'b0 || bus.Error_sequence !== 1'b0) begin
      $display("FAIL %s_err: ovf=%b seq=%b, need 0/0", tag, bus.Error_overflow, bus.Error_sequence);
      mism++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_frame();
    int x0 = xfers, l0 = lasts, wr31 = 0;
    bus.Output_ready = 1'b1;
    first_valid_cyc = -1;
    for (int k = 0; k < NC; k++) begin
      if (k == NC - 1) wr31 = cyc;
      drive_sample(k, DW'(k), DW'(-k), 1'b1);
    end
    idle(0);
    wait_drain(200, 1'b0);
    comps++;
    if (xfers - x0 != 32) begin
      $display("FAIL single_count: got %0d transfers, need 32", xfers - x0); mism++;
    end
    comps++;
    if (lasts - l0 != 1) begin
      $display("FAIL single_last: got %0d last flags, need 1", lasts - l0); mism++;
    end
    comps++;
    if (first_valid_cyc - wr31 != 2) begin
      $display("FAIL single_latency: got %0d cycles, need 2", first_valid_cyc - wr31); mism++;
    end
  endtask

  task automatic test_overflow();
    int o0 = ovf_cnt, s0 = seq_cnt, x0 = xfers;
    bus.Output_ready = 1'b0;
    for (int f = 1; f <= 3; f++) send_frame(f * 1000, f < 3);
    idle(4);
    comps++;
    if (ovf_cnt - o0 != 1) begin
      $display("FAIL ovf_pulses: got %0d, need 1", ovf_cnt - o0); mism++;
    end
    comps++;
    if (seq_cnt - s0 != 0 || xfers - x0 != 0) begin
      $display("FAIL ovf_quiet: seq=%0d xfers=%0d, need 0/0", seq_cnt - s0, xfers - x0); mism++;
    end
    bus.Output_ready = 1'b1;
    wait_drain(400, 1'b0);
    idle(40);
    comps++;
    if (xfers - x0 != 64) begin
      $display("FAIL ovf_outputs: got %0d transfers, need 64", xfers - x0); mism++;
    end
  endtask

  task automatic test_sequence();
    int o0 = ovf_cnt, s0 = seq_cnt, x0 = xfers;
    bus.Output_ready = 1'b1;
    drive_sample(0, 25'sd11, -25'sd11, 1'b0);
    drive_sample(1, 25'sd12, -25'sd12, 1'b0);
    drive_sample(2, 25'sd13, -25'sd13, 1'b0);
    drive_sample(5, 25'sd14, -25'sd14, 1'b0);
    idle(6);
    comps++;
    if (seq_cnt - s0 != 1) begin
      $display("FAIL seq_pulses: got %0d, need 1", seq_cnt - s0); mism++;
    end
    comps++;
    if (ovf_cnt - o0 != 0 || xfers - x0 != 0) begin
      $display("FAIL seq_quiet: ovf=%0d xfers=%0d, need 0/0", ovf_cnt - o0, xfers - x0); mism++;
    end
    send_frame(5000, 1'b1);
    wait_drain(200, 1'b0);
    comps++;
    if (xfers - x0 != 32) begin
      $display("FAIL seq_recover: got %0d transfers, need 32", xfers - x0); mism++;
    end
  endtask

  task automatic test_stall();
    int x0 = xfers, s0 = stall_checks;
    bus.Output_ready = 1'b0;
    send_frame(7000 + $urandom_range(0, 500), 1'b1);
    idle(2);
    wait_drain(300, 1'b1);
    bus.Output_ready = 1'b1;
    idle(2);
    comps++;
    if (xfers - x0 != 32) begin
      $display("FAIL stall_count: got %0d transfers, need 32", xfers - x0); mism++;
    end
    comps++;
    if (stall_checks - s0 < 16) begin
      $display("FAIL stall_seen: got %0d stalled cycles, need >=16", stall_checks - s0); mism++;
    end
  endtask

  task automatic test_back_to_back();
    int x0 = xfers, l0 = lasts;
    bus.Output_ready = 1'b1;
    send_frame(20000, 1'b1);
    send_frame(30000, 1'b1);
    wait_drain(300, 1'b0);
    idle(2);
    comps++;
    if (xfers - x0 != 64 || lasts - l0 != 2) begin
      $display("FAIL b2b_count: xfers=%0d lasts=%0d, need 64/2", xfers - x0, lasts - l0); mism++;
    end
  endtask

  task automatic test_reset_mid();
    int x0 = xfers, n = 0;
    bus.Output_ready = 1'b1;
    for (int k = 0; k <= 15; k++) drive_sample(k, DW'(k + 77), DW'(k - 77), 1'b0);
    bus.Input_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("rst_midframe");
    rst = 1'b0;
    for (int k = 16; k < NC; k++) drive_sample(k, DW'(k), DW'(k), 1'b0);
    idle(10);
    bus.Output_ready = 1'b0;
    send_frame(40000, 1'b0);
    while (bus.Output_valid !== 1'b1 && n < 10) begin idle(1); n++; end
    comps++;
    if (bus.Output_valid !== 1'b1) begin
      $display("FAIL rst_readout_start: Output_valid=%b, need 1", bus.Output_valid); mism++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("rst_readout");
    rst = 1'b0;
    bus.Output_ready = 1'b1;
    idle(10);
    comps++;
    if (xfers - x0 != 0) begin
      $display("FAIL rst_stale: got %0d transfers, need 0", xfers - x0); mism++;
    end
    send_frame(50000, 1'b1);
    wait_drain(200, 1'b0);
    comps++;
    if (xfers - x0 != 32) begin
      $display("FAIL rst_recover: got %0d transfers, need 32", xfers - x0); mism++;
    end
  endtask

  task automatic test_extreme();
    int x0 = xfers;
    bus.Output_ready = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (k % 2 == 0) drive_sample(k, MAX_V, MIN_V, 1'b1);
      else            drive_sample(k, MIN_V, MAX_V, 1'b1);
    end
    idle(0);
    wait_drain(200, 1'b0);
    comps++;
    if (xfers - x0 != 32) begin
      $display("FAIL extreme_count: got %0d transfers, need 32", xfers - x0); mism++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.Input_valid   = 1'b0;
    bus.Input_index   = '0;
    bus.Input_data[0] = '0;
    bus.Input_data[1] = '0;
    bus.Output_ready  = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_sequence();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_extreme();
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, mism);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
